// File: rtl/mem_io_responder_pkg.sv
// Shared constants and helpers for the memory/IO responder slice.
package mem_io_responder_pkg;

  localparam int DATA_WIDTH                 = 8;
  localparam int RAM_ADDR_WIDTH_DEFAULT     = 17;
  localparam int TX_FIFO_DEPTH_LOG2_DEFAULT = 4;

  localparam logic [1:0]  IO_REGION    = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  // Address space split on mem_a[17:16].
  typedef enum logic [1:0] {
    REGION_RAM_LO = 2'b00,
    REGION_RAM_HI = 2'b01,
    REGION_NONE   = 2'b10,
    REGION_IO     = IO_REGION
  } region_e;

  // Byte idx (0..3) of a 32-bit word, little-endian.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = word >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/memio_tx_fifo.sv
// Synchronous FIFO for UART TX bytes. A push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle. nearly_full is
// registered and reflects the post-update occupancy.
module memio_tx_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2_DEFAULT,
  parameter int WIDTH      = DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  en,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic                  nearly_full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] NEAR_CNT = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]      store [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign dout    = store[rd_ptr];
  assign do_pop  = en && pop && !empty;
  assign do_push = en && push && (!full || do_pop);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // Pointer, count and nearly_full registers; pointers wrap by width.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_in) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      nearly_full <= 1'b0;
    end else if (en) begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      nearly_full <= (count_next >= NEAR_CNT);
    end
  end

  // Data storage write port.
  always_ff @(posedge clk_in) begin
    // NOTE: storage is not reset; only pointers and count define what is valid.
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: RAM array, I/O decode (UART TX/RX,
// cycle counter with coherent snapshot, program stop) and io_buffer_full.
// Optional macro MEMIO_SIM_PRINT_EN adds simulation console output and
// a $finish two cycles after program_stop is set.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH     = RAM_ADDR_WIDTH_DEFAULT,
  parameter int TX_FIFO_DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_pop,
  output logic        program_stop
);

  logic [7:0] ram [2**RAM_ADDR_WIDTH];

  region_e                   region;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [2:0]                io_off;
  logic                      ram_sel;
  logic                      io_rd;
  logic                      io_wr;
  logic                      snap_latch;
  logic                      stop_set;
  logic                      tx_push_req;
  logic                      tx_drop;
  logic                      tx_empty;
  logic                      tx_full;
  logic [TX_FIFO_DEPTH_LOG2:0] tx_count;
  logic [7:0]                rd_data;
  logic [31:0]               counter;
  logic [31:0]               snapshot;
  logic                      tx_overflow;

  assign region   = region_e'(mem_a[17:16]);
  assign ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];
  assign io_off   = mem_a[2:0];
  assign ram_sel  = (region == REGION_RAM_LO) || (region == REGION_RAM_HI);

  // Side effects only fire on enabled, non-reset cycles.
  assign io_rd = rdy_in && !rst_in && !mem_wr && (region == REGION_IO);
  assign io_wr = rdy_in && !rst_in &&  mem_wr && (region == REGION_IO);

  assign uart_rx_pop = io_rd && (io_off == IO_UART_ADDR[2:0]) && uart_rx_valid;
  assign snap_latch  = io_rd && (io_off == IO_CLK_ADDR[2:0]);
  assign stop_set    = io_wr && (io_off == IO_CLK_ADDR[2:0]);
  assign tx_push_req = io_wr && (io_off == IO_UART_ADDR[2:0]) && (mem_dout != 8'h00);
  assign tx_drop     = tx_push_req && tx_full && !(uart_tx_valid && uart_tx_ready);

  assign uart_tx_valid = !tx_empty;

  // tx_overflow is a sticky debug flag with no port; tx_count is informational.
  logic unused_bits;
  assign unused_bits = ^{mem_a[31:18], tx_overflow, tx_count};

  memio_tx_fifo #(
    .DEPTH_LOG2 (TX_FIFO_DEPTH_LOG2),
    .WIDTH      (DATA_WIDTH)
  ) u_tx_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en          (rdy_in),
    .push        (tx_push_req),
    .pop         (uart_tx_ready),
    .din         (mem_dout),
    .dout        (uart_tx_data),
    .empty       (tx_empty),
    .full        (tx_full),
    .nearly_full (io_buffer_full),
    .count       (tx_count)
  );

  // Read data mux: RAM, zero hole, or I/O register selected by offset.
  always_comb begin
    rd_data = 8'h00;
    case (region)
      REGION_RAM_LO, REGION_RAM_HI: rd_data = ram[ram_addr];
      REGION_IO: begin
        case (io_off)
          IO_UART_ADDR[2:0]: rd_data = uart_rx_valid ? uart_rx_data : 8'h00;
          IO_CLK_ADDR[2:0]:  rd_data = counter[7:0];
          3'd5, 3'd6, 3'd7:  rd_data = word_byte(snapshot, io_off[1:0]);
          default:           rd_data = 8'h00;
        endcase
      end
      default: rd_data = 8'h00;
    endcase
  end

  // RAM write port; reads go through rd_data into mem_din.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in && mem_wr && ram_sel) ram[ram_addr] <= mem_dout;
  end

  // Read register, cycle counter, snapshot, stop and overflow flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din      <= 8'h00;
      counter      <= '0;
      snapshot     <= '0;
      program_stop <= 1'b0;
      tx_overflow  <= 1'b0;
    end else if (rdy_in) begin
      if (!program_stop) counter <= counter + 32'd1;
      if (!mem_wr)       mem_din <= rd_data;
      if (snap_latch)    snapshot <= counter;
      if (stop_set)      program_stop <= 1'b1;
      if (tx_drop)       tx_overflow <= 1'b1;
    end
  end

`ifdef MEMIO_SIM_PRINT_EN
  logic [1:0] finish_cnt;

  // Console echo of TX bytes and delayed end of simulation on program stop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      finish_cnt <= 2'd0;
    end else begin
      if (tx_push_req && !tx_drop) $write("%c", mem_dout);
      if (stop_set && !program_stop) begin
        $display("program stop at cycle %0d", counter);
        finish_cnt <= 2'd2;
      end else if (finish_cnt == 2'd1) begin
        $finish;
      end else if (finish_cnt != 2'd0) begin
        finish_cnt <= finish_cnt - 2'd1;
      end
    end
  end
`else
`endif

endmodule
